morse_timing_decoder: RTL and testbench

MORSE_TIMING_DECODER -- requirements
Module: Morse_Timing_Decoder

---
 rtl/morse_timing_decoder.sv | 184 ++++++++++++++++++
 tb/tb_morse_timing_decoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/morse_timing_decoder.sv
// Morse key timing decoder.
// Splits key presses into dots and dashes by counting half-second ticks while
// the key is held. A letter ends when the key stays released long enough.
// Each finished letter is presented on oCode/oLen with a one-cycle oValid
// pulse. A letter that grows past MAX_LEN elements is dropped with a
// one-cycle oOverflow pulse.
module morse_timing_decoder #(
   parameter int DASH_HS = 2,  // shortest press, in ticks, that counts as a dash
   parameter int GAP_HS  = 2,  // release length, in ticks, that ends a letter
   parameter int MAX_LEN = 5   // elements per letter; oLen is 3 bits, so at most 7
) (
   input  logic               iCLK,
   input  logic               iRST,
   input  logic               iKey,
   input  logic [3:0]         iHalfSec,
   output logic [MAX_LEN-1:0] oCode,
   output logic [2:0]         oLen,
   output logic               oValid,
   output logic               oOverflow,
   output logic               oKeyActive
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PRESS = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   // Gap counter is one bit wider than needed to reach GAP_HS, so it
   // saturates above the threshold and cannot wrap back onto it.
   localparam int            GAP_W   = $clog2(GAP_HS + 1) + 1;
   localparam logic [2:0]    DASH_TH = 3'(DASH_HS);
   localparam logic [GAP_W-1:0] GAP_TH = GAP_W'(GAP_HS);
   localparam logic [2:0]    LEN_MAX = 3'(MAX_LEN);

   state_t             state_q, state_d;
   logic [3:0]         hs_q;
   logic               hs_loaded_q;
   logic               key_q;
   logic [2:0]         dur_q, dur_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [2:0]         len_q, len_d;
   logic [MAX_LEN-1:0] elem_q, elem_d;
   logic [MAX_LEN-1:0] code_q, code_d;
   logic [2:0]         olen_q, olen_d;
   logic               valid_q, valid_d;
   logic               ovf_q, ovf_d;
   logic               key_active_q, key_active_d;

   logic               tick;
   logic               rise;
   logic               fall;
   logic [2:0]         dur_inc;
   logic [2:0]         dur_new;
   logic [GAP_W-1:0]   gap_inc;

   // A tick is any change of the free-running half-second count (wrap
   // included). The first cycle after reset only loads the copy, so a stale
   // reset value of hs_q cannot produce a spurious tick.
   assign tick = hs_loaded_q && (iHalfSec != hs_q);

   // key_q resets to 1, so a key held through reset must be released and
   // pressed again before it is seen as a rise.
   assign rise = iKey & ~key_q;
   assign fall = ~iKey & key_q;

   assign dur_inc = (dur_q == 3'd7) ? dur_q : dur_q + 3'd1;
   assign gap_inc = (gap_q == '1) ? gap_q : gap_q + 1'b1;

   // Input history: registered half-second count and key level.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         hs_q        <= 4'd0;
         hs_loaded_q <= 1'b0;
         key_q       <= 1'b1;
      end else begin
         // NOTE: registers take non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         hs_q        <= iHalfSec;
         hs_loaded_q <= 1'b1;
         key_q       <= iKey;
      end
   end

   // State, counters, letter buffer and registered outputs.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q      <= S_IDLE;
         dur_q        <= 3'd0;
         gap_q        <= '0;
         len_q        <= 3'd0;
         elem_q       <= '0;
         code_q       <= '0;
         olen_q       <= 3'd0;
         valid_q      <= 1'b0;
         ovf_q        <= 1'b0;
         key_active_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         dur_q        <= dur_d;
         gap_q        <= gap_d;
         len_q        <= len_d;
         elem_q       <= elem_d;
         code_q       <= code_d;
         olen_q       <= olen_d;
         valid_q      <= valid_d;
         ovf_q        <= ovf_d;
         key_active_q <= key_active_d;
      end
   end

   // Next-state logic: element classification, letter termination, overflow.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      dur_d    = dur_q;
      gap_d    = gap_q;
      len_d    = len_q;
      elem_d   = elem_q;
      code_d   = code_q;
      olen_d   = olen_q;
      valid_d  = 1'b0;
      ovf_d    = 1'b0;
      dur_new  = dur_q;

      case (state_q)
         S_IDLE: begin
            if (rise) begin
               state_d = S_PRESS;
               dur_d   = 3'd0;
            end
         end

         S_PRESS: begin
            // A tick landing on the release edge still counts toward the press.
            dur_new = tick ? dur_inc : dur_q;
            dur_d   = dur_new;
            if (fall) begin
               if (len_q == LEN_MAX) begin
                  ovf_d   = 1'b1;
                  elem_d  = '0;
                  len_d   = 3'd0;
                  state_d = S_IDLE;
               end else begin
                  elem_d[len_q] = (dur_new >= DASH_TH);
                  len_d         = len_q + 3'd1;
                  gap_d         = '0;
                  state_d       = S_GAP;
               end
            end
         end

         S_GAP: begin
            // A new press wins over a coinciding tick and extends the letter.
            if (rise) begin
               state_d = S_PRESS;
               dur_d   = 3'd0;
            end else if (tick) begin
               gap_d = gap_inc;
               if (gap_inc == GAP_TH) begin
                  code_d  = elem_q;
                  olen_d  = len_q;
                  valid_d = 1'b1;
                  elem_d  = '0;
                  len_d   = 3'd0;
                  state_d = S_IDLE;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase

      key_active_d = (state_d == S_PRESS);
   end

   assign oCode      = code_q;
   assign oLen       = olen_q;
   assign oValid     = valid_q;
   assign oOverflow  = ovf_q;
   assign oKeyActive = key_active_q;

endmodule

// File: tb/tb_morse_timing_decoder.sv
// Directed bench for morse_timing_decoder: letters are keyed in a linear
// sequence, each expected letter or overflow is queued when its stimulus is
// driven, and a monitor pops and compares whenever the decoder pulses.
module tb_morse_timing_decoder;

   logic       clk;
   logic       rst;
   logic       key;
   logic [3:0] hs;
   logic [4:0] oCode;
   logic [2:0] oLen;
   logic       oValid;
   logic       oOverflow;
   logic       oKeyActive;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit         ovf;
      logic [4:0] code;
      logic [2:0] len;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   morse_timing_decoder #(
      .DASH_HS(2),
      .GAP_HS (2),
      .MAX_LEN(5)
   ) dut (
      .iCLK      (clk),
      .iRST      (rst),
      .iKey      (key),
      .iHalfSec  (hs),
      .oCode     (oCode),
      .oLen      (oLen),
      .oValid    (oValid),
      .oOverflow (oOverflow),
      .oKeyActive(oKeyActive)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic tick_step();
      hs = hs + 4'd1;
      @(negedge clk);
   endtask

   task automatic expect_letter(input logic [4:0] code, input logic [2:0] len);
      exp_t e;
      e.ovf  = 1'b0;
      e.code = code;
      e.len  = len;
      sb.push_back(e);
   endtask

   task automatic expect_overflow();
      exp_t e;
      e.ovf  = 1'b1;
      e.code = 5'd0;
      e.len  = 3'd0;
      sb.push_back(e);
   endtask

   // Scoreboard monitor: every pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && (oValid || oOverflow)) begin
         chk("pulse_exclusive", {31'd0, oValid & oOverflow}, 32'd0);
         chk("pulse_expected", {31'd0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("pulse_is_overflow", {31'd0, oOverflow}, {31'd0, mon_e.ovf});
            if (!mon_e.ovf) begin
               chk("letter_code", {27'd0, oCode}, {27'd0, mon_e.code});
               chk("letter_len", {29'd0, oLen}, {29'd0, mon_e.len});
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      key = 1'b0;
      hs  = 4'd0;
      repeat (3) step();
      chk("reset_code", {27'd0, oCode}, 32'd0);
      chk("reset_len", {29'd0, oLen}, 32'd0);
      chk("reset_valid", {31'd0, oValid}, 32'd0);
      chk("reset_ovf", {31'd0, oOverflow}, 32'd0);
      chk("reset_keyactive", {31'd0, oKeyActive}, 32'd0);
      rst = 1'b0;
      repeat (2) step();

      // "E": one-tick press is a dot, two ticks of gap end the letter.
      key = 1'b1; step();
      chk("E_keyactive_press", {31'd0, oKeyActive}, 32'd1);
      tick_step();
      key = 1'b0; step();
      chk("E_keyactive_release", {31'd0, oKeyActive}, 32'd0);
      tick_step();
      expect_letter(5'b00000, 3'd1);
      tick_step();
      repeat (2) step();
      chk("E_hold_code", {27'd0, oCode}, 32'd0);
      chk("E_hold_len", {29'd0, oLen}, 32'd1);

      // "N": 3-tick dash, 1-tick gap, zero-tick dot, 2-tick gap.
      key = 1'b1; step();
      chk("N_keyactive_dash", {31'd0, oKeyActive}, 32'd1);
      repeat (3) tick_step();
      key = 1'b0; step();
      chk("N_keyactive_gap", {31'd0, oKeyActive}, 32'd0);
      tick_step();
      key = 1'b1; step();
      chk("N_keyactive_dot", {31'd0, oKeyActive}, 32'd1);
      key = 1'b0; step();
      tick_step();
      expect_letter(5'b00001, 3'd2);
      tick_step();
      repeat (2) step();
      chk("N_hold_code", {27'd0, oCode}, 32'd1);
      chk("N_hold_len", {29'd0, oLen}, 32'd2);

      // Six dots with 1-tick gaps: the sixth release overflows.
      for (int i = 0; i < 5; i++) begin
         key = 1'b1; step();
         key = 1'b0; step();
         tick_step();
      end
      key = 1'b1; step();
      expect_overflow();
      key = 1'b0; step();
      repeat (3) tick_step();
      chk("ovf_hold_code", {27'd0, oCode}, 32'd1);
      chk("ovf_hold_len", {29'd0, oLen}, 32'd2);

      // "T" after overflow: 2-tick press is exactly a dash.
      key = 1'b1; step();
      repeat (2) tick_step();
      key = 1'b0; step();
      tick_step();
      expect_letter(5'b00001, 3'd1);
      tick_step();
      repeat (2) step();
      chk("T_len", {29'd0, oLen}, 32'd1);

      // "M": release on the 2nd tick is a dash; rise on the closing gap
      // tick keeps the letter open.
      key = 1'b1; step();
      tick_step();
      key = 1'b0; hs = hs + 4'd1; step();
      tick_step();
      key = 1'b1; hs = hs + 4'd1; step();
      chk("M_rise_wins", {31'd0, oKeyActive}, 32'd1);
      repeat (2) tick_step();
      key = 1'b0; step();
      tick_step();
      expect_letter(5'b00011, 3'd2);
      tick_step();
      repeat (2) step();
      chk("M_hold_code", {27'd0, oCode}, 32'd3);

      // Key held across reset is ignored until released and pressed again.
      key = 1'b1; rst = 1'b1; step();
      step();
      rst = 1'b0;
      repeat (3) step();
      chk("held_key_ignored", {31'd0, oKeyActive}, 32'd0);
      repeat (2) tick_step();
      chk("held_key_still_idle", {31'd0, oKeyActive}, 32'd0);
      key = 1'b0; step();
      key = 1'b1; step();
      chk("held_key_new_press", {31'd0, oKeyActive}, 32'd1);
      key = 1'b0; step();
      tick_step();
      expect_letter(5'b00000, 3'd1);
      tick_step();
      repeat (2) step();
      chk("held_key_letter_len", {29'd0, oLen}, 32'd1);

      // Press spanning the 15->0 wrap of the half-second count.
      hs = 4'd14; step();
      key = 1'b1; step();
      repeat (2) tick_step();
      chk("wrap_hs_zero", {28'd0, hs}, 32'd0);
      key = 1'b0; step();
      tick_step();
      expect_letter(5'b00001, 3'd1);
      tick_step();
      repeat (2) step();
      chk("wrap_code", {27'd0, oCode}, 32'd1);
      chk("wrap_len", {29'd0, oLen}, 32'd1);

      // Reset in the gap after three elements: outputs clear at once and the
      // partial letter never emerges.
      for (int i = 0; i < 3; i++) begin
         key = 1'b1; step();
         key = 1'b0; step();
         if (i < 2) tick_step();
      end
      rst = 1'b1;
      #1;
      chk("async_rst_code", {27'd0, oCode}, 32'd0);
      chk("async_rst_len", {29'd0, oLen}, 32'd0);
      chk("async_rst_valid", {31'd0, oValid}, 32'd0);
      chk("async_rst_ovf", {31'd0, oOverflow}, 32'd0);
      chk("async_rst_keyactive", {31'd0, oKeyActive}, 32'd0);
      repeat (2) step();
      rst = 1'b0;
      step();
      repeat (3) tick_step();
      repeat (3) step();
      chk("post_rst_len", {29'd0, oLen}, 32'd0);

      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
